// File: rtl/bcd_scan_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_counter_pkg
// Description : Shared constants and the single-digit BCD step helper.
// Revision    : 1.0
// ============================================================================
package bcd_scan_counter_pkg;

    localparam int DIGITS = 4;
    localparam int BCD_W  = 4;
    localparam logic [DIGITS-1:0] SEL_IDLE = 4'b1111;

    // Returns {digit_next, carry_out}; carry_out flags a 9->0 or 0->9 roll.
    function automatic logic [BCD_W:0] bcd_digit_step(
        input logic [BCD_W-1:0] digit,
        input logic             up,
        input logic             carry_in
    );
        logic [BCD_W:0] w_res;
        w_res = {digit, 1'b0};
        if (carry_in) begin
            if (up) begin
                w_res = (digit >= BCD_W'(9)) ? {BCD_W'(0), 1'b1}
                                             : {digit + BCD_W'(1), 1'b0};
            end else begin
                w_res = (digit == BCD_W'(0)) ? {BCD_W'(9), 1'b1}
                                             : {digit - BCD_W'(1), 1'b0};
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_counter_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One BCD digit, up/down, with ripple carry/borrow in and out.
// Revision    : 1.0
// ============================================================================
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             up,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    logic [BCD_W-1:0] r_digit;
    logic [BCD_W:0]   w_step;

    assign w_step    = bcd_digit_step(r_digit, up, carry_in);
    assign carry_out = w_step[0];
    assign digit     = r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (load) begin
            // Non-decimal nibbles are coerced to zero.
            r_digit <= (load_digit > BCD_W'(9)) ? '0 : load_digit;
        end else if (carry_in) begin
            r_digit <= w_step[BCD_W:1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_counter
// Description : Four-digit BCD up/down counter with prescaler and digit scan.
// Revision    : 1.0
// ============================================================================
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SCAN_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    load,
    input  logic [DIGITS*BCD_W-1:0] load_val,
    input  logic                    blank,
    output logic [DIGITS*BCD_W-1:0] count,
    output logic [BCD_W-1:0]        data,
    output logic [DIGITS-1:0]       sel_n,
    output logic                    wrap
);

    localparam int c_PRESC_W = $clog2(TICK_DIV);
    localparam int c_SCAN_W  = $clog2(SCAN_DIV);
    localparam int c_IDX_W   = $clog2(DIGITS);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0]    c_SEL_ONE    = DIGITS'(1);

    logic [c_PRESC_W-1:0] r_presc;
    logic [c_SCAN_W-1:0]  r_scan;
    logic [c_IDX_W-1:0]   r_idx;
    logic [BCD_W-1:0]     r_data;
    logic [DIGITS-1:0]    r_sel_n;
    logic                 r_wrap;

    logic                 w_step;
    logic [DIGITS:0]      w_carry;
    logic [DIGITS-1:0]    w_hi_zero;
    logic [c_IDX_W-1:0]   w_idx_next;
    logic                 w_blank;
    logic [BCD_W-1:0]     w_nib;

    assign w_step     = en && (r_presc == c_PRESC_LAST);
    assign w_carry[0] = w_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clr) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= (r_presc == c_PRESC_LAST) ? '0 : r_presc + c_PRESC_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .clr        (clr),
                .load       (load),
                .load_digit (load_val[i*BCD_W +: BCD_W]),
                .up         (up),
                .carry_in   (w_carry[i]),
                .digit      (count[i*BCD_W +: BCD_W]),
                .carry_out  (w_carry[i+1])
            );
            assign w_hi_zero[i] = (count[DIGITS*BCD_W-1 : i*BCD_W] == '0);
        end
    endgenerate

    // A carry out of the top digit is a full-range roll; clr/load suppress it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[DIGITS] && !clr && !load;
        end
    end

    assign w_idx_next = r_idx + c_IDX_W'(1);
    assign w_nib      = count[w_idx_next*BCD_W +: BCD_W];
    assign w_blank    = blank && (w_idx_next != '0) && w_hi_zero[w_idx_next];

    // data/sel_n are sampled only at slot boundaries so a mid-slot count
    // change never ghosts onto the wrong digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_sel_n <= ~c_SEL_ONE;
        end else if (r_scan == c_SCAN_LAST) begin
            r_scan  <= '0;
            r_idx   <= w_idx_next;
            r_data  <= w_blank ? '0 : w_nib;
            r_sel_n <= w_blank ? SEL_IDLE : ~(c_SEL_ONE << w_idx_next);
        end else begin
            r_scan  <= r_scan + c_SCAN_W'(1);
        end
    end

    assign data  = r_data;
    assign sel_n = r_sel_n;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_scan_counter
// Description : Directed bench for bcd_scan_counter, TICK_DIV=4, SCAN_DIV=2.
// Revision    : 1.0
// ============================================================================
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        blank;
    logic [15:0] count;
    logic [3:0]  data;
    logic [3:0]  sel_n;
    logic        wrap;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;

    bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .blank    (blank),
        .count    (count),
        .data     (data),
        .sel_n    (sel_n),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_sel(input int idx);
        logic [3:0] w_one;
        w_one = 4'b0001;
        return ~(w_one << idx);
    endfunction

    initial begin
        int          idx;
        logic [3:0]  exp_data;
        logic [15:0] v;

        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 16'h0000; blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 16'h0000);
        chk("rst_sel_n", {12'h0, sel_n}, 16'h000E);
        chk("rst_data", {12'h0, data}, 16'h0000);
        chk("rst_wrap", {15'h0, wrap}, 16'h0000);

        // Free run: one step per 4 clocks, one scan slot per 2 clocks.
        rst_n = 1'b1; en = 1'b1; cyc = 0;
        exp_data = 4'h0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            idx = (k / 2) % 4;
            if (k % 2 == 0) begin
                v = to_bcd((k - 1) / 4);
                exp_data = v[idx*4 +: 4];
            end
            chk("run_count", count, to_bcd(k / 4));
            chk("run_sel_n", {12'h0, sel_n}, {12'h0, exp_sel(idx)});
            chk("run_data", {12'h0, data}, {12'h0, exp_data});
            chk("run_wrap", {15'h0, wrap}, 16'h0000);
        end
        chk("run_final", count, 16'h0010);

        // Load 9998 then count up through 9999 to 0000.
        load_val = 16'h9998; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("load_9998", count, 16'h9998);
        for (int a = 1; a <= 8; a++) begin
            tick(1);
            case (a)
                1, 2:       chk("up_count", count, 16'h9998);
                3, 4, 5, 6: chk("up_count", count, 16'h9999);
                default:    chk("up_count", count, 16'h0000);
            endcase
            chk("up_wrap", {15'h0, wrap}, (a == 7) ? 16'h0001 : 16'h0000);
        end

        // Count down from 0000 wraps to 9999.
        up = 1'b0;
        tick(2);
        chk("dn_pre", count, 16'h0000);
        tick(1);
        chk("dn_count", count, 16'h9999);
        chk("dn_wrap", {15'h0, wrap}, 16'h0001);
        tick(1);
        chk("dn_wrap_end", {15'h0, wrap}, 16'h0000);
        load_val = 16'h0000; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("dn_load0", count, 16'h0000);
        tick(1);
        // Load coincides with a down step that would otherwise wrap.
        load_val = 16'h12A4; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("load_vs_step", count, 16'h1204);
        chk("load_vs_step_wrap", {15'h0, wrap}, 16'h0000);

        // clr on the same edge as a step strobe.
        tick(3);
        chk("pre_clr", count, 16'h1204);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_count", count, 16'h0000);
        chk("clr_wrap", {15'h0, wrap}, 16'h0000);
        up = 1'b1;
        tick(3);
        chk("clr_presc_3", count, 16'h0000);
        tick(1);
        chk("clr_presc_4", count, 16'h0001);
        chk("clr_next_wrap", {15'h0, wrap}, 16'h0000);

        // Leading-zero blanking on 0042, count frozen.
        en = 1'b0; blank = 1'b1; load_val = 16'h0042; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("blank_load", count, 16'h0042);
        tick(2);
        for (int s = 0; s < 8; s++) begin
            tick(1);
            idx = (cyc / 2) % 4;
            case (idx)
                0: begin
                    chk("blk_sel0", {12'h0, sel_n}, 16'h000E);
                    chk("blk_dat0", {12'h0, data}, 16'h0002);
                end
                1: begin
                    chk("blk_sel1", {12'h0, sel_n}, 16'h000D);
                    chk("blk_dat1", {12'h0, data}, 16'h0004);
                end
                default: begin
                    chk("blk_sel_hi", {12'h0, sel_n}, 16'h000F);
                    chk("blk_dat_hi", {12'h0, data}, 16'h0000);
                end
            endcase
        end
        blank = 1'b0;
        tick(2);
        for (int s = 0; s < 8; s++) begin
            tick(1);
            idx = (cyc / 2) % 4;
            chk("noblk_sel", {12'h0, sel_n}, {12'h0, exp_sel(idx)});
            chk("noblk_dat", {12'h0, data}, (idx == 0) ? 16'h0002 : (idx == 1) ? 16'h0004 : 16'h0000);
        end

        // Asynchronous reset mid-slot.
        load_val = 16'h0573; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("pre_rst_count", count, 16'h0573);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 16'h0000);
        chk("arst_sel_n", {12'h0, sel_n}, 16'h000E);
        chk("arst_data", {12'h0, data}, 16'h0000);
        chk("arst_wrap", {15'h0, wrap}, 16'h0000);
        @(posedge clk);
        #1;
        chk("arst_hold_sel", {12'h0, sel_n}, 16'h000E);
        rst_n = 1'b1; cyc = 0;
        for (int s = 1; s <= 4; s++) begin
            tick(1);
            chk("post_rst_sel", {12'h0, sel_n}, {12'h0, exp_sel((cyc / 2) % 4)});
            chk("post_rst_count", count, 16'h0000);
            chk("post_rst_data", {12'h0, data}, 16'h0000);
            chk("post_rst_wrap", {15'h0, wrap}, 16'h0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
